// File: rtl/cpu_control_unit_pkg.sv
// ============================================================================
// Module   : cpu_control_unit_pkg
// Brief    : Shared codes for the 8-bit CPU control unit: instruction
//            classes, branch conditions, system ops, ALU ops, FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_control_unit_pkg;

    typedef enum logic [1:0] {
        CLS_ALU_RR = 2'b00,
        CLS_ALU_RI = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_SYS    = 2'b11
    } instr_class_t;

    typedef enum logic [3:0] {
        COND_ALWAYS = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_C      = 4'd3,
        COND_NC     = 4'd4,
        COND_N      = 4'd5,
        COND_V      = 4'd6,
        COND_NEVER  = 4'd7
    } branch_cond_t;

    typedef enum logic [3:0] {
        SYS_NOP  = 4'd0,
        SYS_HALT = 4'd1,
        SYS_RETI = 4'd2
    } sys_op_t;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SHR    = 4'd7,
        OP_PASS_B = 4'd8,
        OP_MOVE   = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH0 = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALT   = 3'd3,
        ST_IRQ    = 3'd4
    } ctrl_state_t;

    // Bit positions inside the packed {Z,C,V,N} status word
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
// ============================================================================
// Module   : cpu_control_unit_if
// Brief    : Memory, ALU, register-file and status bundle of the control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_control_unit_if;
    logic [7:0] mem_addr_o;
    logic       mem_rd_o;
    logic [7:0] mem_rdata_i;
    logic       mem_ready_i;
    logic [3:0] alu_op_o;
    logic       alu_b_imm_o;
    logic [7:0] imm_o;
    logic [1:0] rf_raddr_a_o;
    logic [1:0] rf_raddr_b_o;
    logic [1:0] rf_waddr_o;
    logic       rf_we_o;
    logic       alu_z_i;
    logic       alu_c_i;
    logic       alu_v_i;
    logic       alu_n_i;
    logic [3:0] flags_o;
    logic [7:0] pc_o;
    logic       halted_o;
    logic       irq_i;

    modport master (
        output mem_addr_o, mem_rd_o, alu_op_o, alu_b_imm_o, imm_o,
               rf_raddr_a_o, rf_raddr_b_o, rf_waddr_o, rf_we_o,
               flags_o, pc_o, halted_o,
        input  mem_rdata_i, mem_ready_i, alu_z_i, alu_c_i, alu_v_i,
               alu_n_i, irq_i
    );

    modport slave (
        input  mem_addr_o, mem_rd_o, alu_op_o, alu_b_imm_o, imm_o,
               rf_raddr_a_o, rf_raddr_b_o, rf_waddr_o, rf_we_o,
               flags_o, pc_o, halted_o,
        output mem_rdata_i, mem_ready_i, alu_z_i, alu_c_i, alu_v_i,
               alu_n_i, irq_i
    );
endinterface

`default_nettype wire

// File: rtl/cpu_branch_cond.sv
// ============================================================================
// Module   : cpu_branch_cond
// Brief    : Combinational branch resolver, (cond, {Z,C,V,N}) -> taken.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_branch_cond
    import cpu_control_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags[FLAG_Z];
            COND_NZ:     taken = ~flags[FLAG_Z];
            COND_C:      taken = flags[FLAG_C];
            COND_NC:     taken = ~flags[FLAG_C];
            COND_N:      taken = flags[FLAG_N];
            COND_V:      taken = flags[FLAG_V];
            default:     taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// Module   : cpu_control_unit
// Brief    : Fetch/decode/execute sequencer of the 8-bit CPU. Optional
//            interrupt support is enabled with the CTRL_IRQ_EN macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [7:0] IRQ_VECTOR = 8'hF0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cpu_control_unit_if.master    bus
);

    ctrl_state_t state, state_next;
    logic [7:0]  pc, pc_next;
    logic [3:0]  flags, flags_next;
    logic [7:0]  ir0, ir0_next;
    logic [7:0]  ir1, ir1_next;

    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [3:0]  alu_op;
    logic        alu_b_imm;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic        branch_taken;

    logic [1:0]  cls;
    logic [3:0]  op;
    logic [1:0]  dst;

    assign cls = ir0[7:6];
    assign op  = ir0[5:2];
    assign dst = ir0[1:0];

`ifdef CTRL_IRQ_EN
    logic [7:0] shadow_pc, shadow_pc_next;
    logic [3:0] shadow_flags, shadow_flags_next;
    logic       in_irq, in_irq_next;
    logic       irq_take;

    assign irq_take = bus.irq_i & ~in_irq;
`else
    logic [7:0] unused_irq;
    assign unused_irq = IRQ_VECTOR ^ {7'd0, bus.irq_i};
`endif

    cpu_branch_cond u_branch_cond (
        .cond  (op),
        .flags (flags),
        .taken (branch_taken)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_FETCH0;
            pc    <= RESET_PC;
            flags <= 4'd0;
            ir0   <= 8'd0;
            ir1   <= 8'd0;
`ifdef CTRL_IRQ_EN
            shadow_pc    <= 8'd0;
            shadow_flags <= 4'd0;
            in_irq       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            pc    <= pc_next;
            flags <= flags_next;
            ir0   <= ir0_next;
            ir1   <= ir1_next;
`ifdef CTRL_IRQ_EN
            shadow_pc    <= shadow_pc_next;
            shadow_flags <= shadow_flags_next;
            in_irq       <= in_irq_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        flags_next = flags;
        ir0_next   = ir0;
        ir1_next   = ir1;
        mem_addr   = 8'd0;
        mem_rd     = 1'b0;
        alu_op     = 4'd0;
        alu_b_imm  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 2'd0;
`ifdef CTRL_IRQ_EN
        shadow_pc_next    = shadow_pc;
        shadow_flags_next = shadow_flags;
        in_irq_next       = in_irq;
`endif

        case (state)
            ST_FETCH0: begin
                mem_addr = pc;
                mem_rd   = 1'b1;
                if (bus.mem_ready_i) begin
                    ir0_next   = bus.mem_rdata_i;
                    state_next = ST_FETCH1;
                end
            end

            ST_FETCH1: begin
                mem_addr = pc + 8'd1;
                mem_rd   = 1'b1;
                if (bus.mem_ready_i) begin
                    ir1_next   = bus.mem_rdata_i;
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                pc_next    = pc + 8'd2;
                state_next = ST_FETCH0;
                case (cls)
                    CLS_ALU_RR, CLS_ALU_RI: begin
                        alu_op     = op;
                        alu_b_imm  = (cls == CLS_ALU_RI);
                        rf_we      = 1'b1;
                        rf_waddr   = dst;
                        flags_next = {bus.alu_z_i, bus.alu_c_i,
                                      bus.alu_v_i, bus.alu_n_i};
                    end
                    CLS_BRANCH: begin
                        if (branch_taken) begin
                            pc_next = ir1;
                        end
                    end
                    default: begin
                        // HALT still advances past itself so a resumed
                        // interrupt return does not re-execute it.
                        if (op == SYS_HALT) begin
                            state_next = ST_HALT;
                        end
`ifdef CTRL_IRQ_EN
                        if (op == SYS_RETI && in_irq) begin
                            pc_next     = shadow_pc;
                            flags_next  = shadow_flags;
                            in_irq_next = 1'b0;
                        end
`endif
                    end
                endcase
`ifdef CTRL_IRQ_EN
                if (state_next == ST_FETCH0 && irq_take) begin
                    state_next = ST_IRQ;
                end
`endif
            end

            ST_HALT: begin
`ifdef CTRL_IRQ_EN
                if (irq_take) begin
                    state_next = ST_IRQ;
                end
`endif
            end

`ifdef CTRL_IRQ_EN
            ST_IRQ: begin
                shadow_pc_next    = pc;
                shadow_flags_next = flags;
                pc_next           = IRQ_VECTOR;
                in_irq_next       = 1'b1;
                state_next        = ST_FETCH0;
            end
`endif

            default: begin
                state_next = ST_FETCH0;
            end
        endcase
    end

    // Reset must drop the read strobe immediately, not at the next edge
    assign bus.mem_rd_o     = mem_rd & ~rst_i;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.alu_op_o     = alu_op;
    assign bus.alu_b_imm_o  = alu_b_imm;
    assign bus.imm_o        = ir1;
    assign bus.rf_raddr_a_o = dst;
    assign bus.rf_raddr_b_o = ir1[1:0];
    assign bus.rf_waddr_o   = rf_waddr;
    assign bus.rf_we_o      = rf_we;
    assign bus.flags_o      = flags;
    assign bus.pc_o         = pc;
    assign bus.halted_o     = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
// Module   : tb_cpu_control_unit
// Brief    : Directed self-checking bench for cpu_control_unit; covers the
//            interrupt path when CTRL_IRQ_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;
    import cpu_control_unit_pkg::*;

    logic clk;
    logic rst;
    logic hold;
    logic [7:0] mem [256];
    int checks;
    int failures;

    cpu_control_unit_if bus ();

    cpu_control_unit #(
        .RESET_PC   (8'h00),
        .IRQ_VECTOR (8'hF0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.mem_rdata_i = mem[bus.mem_addr_o];
    assign bus.mem_ready_i = ~hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic z, input logic c, input logic v, input logic n);
        bus.alu_z_i = z;
        bus.alu_c_i = c;
        bus.alu_v_i = v;
        bus.alu_n_i = n;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        hold     = 1'b0;
        bus.irq_i = 1'b0;
        set_alu(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h45; mem[8'h01] = 8'h05;   // ADDI r1,#5
        mem[8'h02] = 8'h0A; mem[8'h03] = 8'h03;   // SUB  r2,r3
        mem[8'h04] = 8'h84; mem[8'h05] = 8'h40;   // BZ   0x40
        mem[8'h40] = 8'h48; mem[8'h41] = 8'h00;   // SUBI r0,#0
        mem[8'h42] = 8'h84; mem[8'h43] = 8'h80;   // BZ   0x80 (not taken)
        mem[8'h44] = 8'h9C; mem[8'h45] = 8'h10;   // cond 7: never
        mem[8'h46] = 8'h88; mem[8'h47] = 8'hFF;   // BNZ  0xFF
        mem[8'hFF] = 8'hC0;                       // NOP, byte1 wraps to 0x00

        step(2);
        check("rst_pc", bus.pc_o, 8'h00);
        check("rst_flags", bus.flags_o, 4'h0);
        check("rst_halted", bus.halted_o, 1'b0);
        check("rst_rd", bus.mem_rd_o, 1'b0);
        check("rst_we", bus.rf_we_o, 1'b0);
        check("rst_aluop", bus.alu_op_o, 4'h0);
        check("rst_imm", bus.imm_o, 8'h00);

        rst = 1'b0;
        #1;
        check("f0_rd", bus.mem_rd_o, 1'b1);
        check("f0_addr", bus.mem_addr_o, 8'h00);
        set_alu(1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        check("f1_addr", bus.mem_addr_o, 8'h01);
        check("f1_rd", bus.mem_rd_o, 1'b1);
        check("f1_we", bus.rf_we_o, 1'b0);
        step(1);
        check("addi_we", bus.rf_we_o, 1'b1);
        check("addi_waddr", bus.rf_waddr_o, 2'd1);
        check("addi_aluop", bus.alu_op_o, OP_ADD);
        check("addi_bimm", bus.alu_b_imm_o, 1'b1);
        check("addi_imm", bus.imm_o, 8'h05);
        check("addi_ra", bus.rf_raddr_a_o, 2'd1);
        check("addi_rd", bus.mem_rd_o, 1'b0);
        check("addi_pc_exec", bus.pc_o, 8'h00);
        step(1);
        check("addi_we_off", bus.rf_we_o, 1'b0);
        check("addi_aluop_off", bus.alu_op_o, 4'h0);
        check("addi_pc", bus.pc_o, 8'h02);
        check("addi_flags", bus.flags_o, 4'b0100);

        // SUB r2,r3 with Z=1
        set_alu(1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        check("sub_aluop", bus.alu_op_o, OP_SUB);
        check("sub_bimm", bus.alu_b_imm_o, 1'b0);
        check("sub_rb", bus.rf_raddr_b_o, 2'd3);
        check("sub_waddr", bus.rf_waddr_o, 2'd2);
        step(1);
        check("sub_flags", bus.flags_o, 4'b1000);
        check("sub_pc", bus.pc_o, 8'h04);

        // BZ uses the latched Z, not the live ALU input
        set_alu(1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        check("bz_we", bus.rf_we_o, 1'b0);
        check("bz_aluop", bus.alu_op_o, 4'h0);
        step(1);
        check("bz_taken_pc", bus.pc_o, 8'h40);
        check("bz_flags_kept", bus.flags_o, 4'b1000);
        mem[8'h01] = 8'hC4;                       // HALT
        mem[8'h02] = 8'h77;

        // SUBI at 0x40 with three wait cycles in FETCH1
        set_alu(1'b0, 1'b0, 1'b0, 1'b1);
        step(1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wait_rd", bus.mem_rd_o, 1'b1);
            check("wait_addr", bus.mem_addr_o, 8'h41);
            check("wait_we", bus.rf_we_o, 1'b0);
            step(1);
        end
        hold = 1'b0;
        check("wait_last_addr", bus.mem_addr_o, 8'h41);
        check("wait_last_we", bus.rf_we_o, 1'b0);
        step(1);
        check("subi_we", bus.rf_we_o, 1'b1);
        check("subi_bimm", bus.alu_b_imm_o, 1'b1);
        step(1);
        check("subi_pc", bus.pc_o, 8'h42);
        check("subi_flags", bus.flags_o, 4'b0001);

        step(3);
        check("bz_not_taken_pc", bus.pc_o, 8'h44);
        step(3);
        check("cond7_pc", bus.pc_o, 8'h46);
        step(3);
        check("bnz_pc", bus.pc_o, 8'hFF);

        // Instruction straddling 0xFF/0x00
        step(1);
        check("wrap_f1_addr", bus.mem_addr_o, 8'h00);
        step(1);
        check("wrap_imm", bus.imm_o, 8'h45);
        step(1);
        check("wrap_pc", bus.pc_o, 8'h01);

        // HALT at 0x01
        step(3);
        check("halt_pc", bus.pc_o, 8'h03);
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", bus.halted_o, 1'b1);
            check("halt_rd", bus.mem_rd_o, 1'b0);
            step(1);
        end
        check("halt_pc_frozen", bus.pc_o, 8'h03);
        check("halt_flags", bus.flags_o, 4'b0001);

        // Leave HALT with reset, then reset again in the middle of FETCH1
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        check("restart_halted", bus.halted_o, 1'b0);
        check("restart_rd", bus.mem_rd_o, 1'b1);
        step(1);
        check("pre_rst_ra", bus.rf_raddr_a_o, 2'd1);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_rd", bus.mem_rd_o, 1'b0);
        check("midrst_we", bus.rf_we_o, 1'b0);
        check("midrst_aluop", bus.alu_op_o, 4'h0);
        check("midrst_pc", bus.pc_o, 8'h00);
        check("midrst_flags", bus.flags_o, 4'h0);
        check("midrst_ra", bus.rf_raddr_a_o, 2'd0);
        check("midrst_imm", bus.imm_o, 8'h00);
        check("midrst_halted", bus.halted_o, 1'b0);

`ifdef CTRL_IRQ_EN
        mem[8'hF0] = 8'h45; mem[8'hF1] = 8'h01;   // ADDI r1,#1
        mem[8'hF2] = 8'hC8; mem[8'hF3] = 8'h00;   // RETI
        rst = 1'b0;
        bus.irq_i = 1'b1;
        set_alu(1'b0, 1'b1, 1'b0, 1'b0);
        step(3);
        check("irq_state_pc", bus.pc_o, 8'h02);
        check("irq_state_rd", bus.mem_rd_o, 1'b0);
        step(1);
        check("irq_vector_pc", bus.pc_o, 8'hF0);
        check("irq_flags_before", bus.flags_o, 4'b0100);
        set_alu(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        check("irq_no_nest_pc", bus.pc_o, 8'hF2);
        check("irq_isr_flags", bus.flags_o, 4'b1000);
        bus.irq_i = 1'b0;
        step(3);
        check("reti_pc", bus.pc_o, 8'h02);
        check("reti_flags", bus.flags_o, 4'b0100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
